// File: rtl/tmds_decoder_if.sv
// rtl/tmds_decoder_if.sv - TMDS lane interface: deserialized symbol in, decoded pixel/control out
//
// Purpose: groups the per-lane signals between the deserializer side and the decoder.
// Signals:
//   din      10  deserialized TMDS symbol (bit 0 first on the wire)
//   dout      8  decoded pixel byte, 0 during control periods
//   de        1  1 = data symbol, 0 = control token
//   c0, c1    1  control bits from the last token, held during data
//   vld       1  word alignment locked
//   bitslip   1  one-cycle request to shift the deserializer word boundary
// Modports: master = symbol source / output consumer, slave = the decoder.
interface tmds_decoder_if;
    logic [9:0] din;
    logic [7:0] dout;
    logic       de;
    logic       c0;
    logic       c1;
    logic       vld;
    logic       bitslip;

    modport master (
        output din,
        input  dout, de, c0, c1, vld, bitslip
    );

    modport slave (
        input  din,
        output dout, de, c0, c1, vld, bitslip
    );
endinterface

// File: rtl/tmds_decoder.sv
// rtl/tmds_decoder.sv - single-lane TMDS/DVI 10b->8b decoder with control-token word alignment
//
// Purpose: registers the deserialized symbol, decodes it to pixel data or control
// bits two edges later, and (optionally) runs an alignment state machine that
// pulses bitslip until control tokens are seen reliably, then asserts vld.
// Ports:
//   clkin   in   pixel clock
//   rstin   in   asynchronous active-high reset
//   bus     slave modport of tmds_decoder_if (din in; dout/de/c0/c1/vld/bitslip out)
// Parameters:
//   LOCK_CNT   consecutive tokens required to declare lock (1..255)
//   SEARCH_W   timer width; search / loss-of-lock window is 2^SEARCH_W-1 cycles
//   SLIP_WAIT  idle cycles after each bitslip pulse (1..255)
// Build option: define TMDS_ALIGN_EN to compile in the alignment FSM; without it
//   vld is tied 1, bitslip is tied 0 and the parameters are unused.
module tmds_decoder #(
    parameter int unsigned LOCK_CNT  = 16,
    parameter int unsigned SEARCH_W  = 12,
    parameter int unsigned SLIP_WAIT = 8
) (
    input  logic           clkin,
    input  logic           rstin,
    tmds_decoder_if.slave  bus
);

    localparam logic [9:0] TOK_00 = 10'b1101010100;
    localparam logic [9:0] TOK_01 = 10'b0010101011;
    localparam logic [9:0] TOK_10 = 10'b0101010100;
    localparam logic [9:0] TOK_11 = 10'b1010101011;

    // {hit, c1, c0} for a symbol
    function automatic logic [2:0] tok_lookup(input logic [9:0] sym);
        logic [2:0] r;
        case (sym)
            TOK_00:  r = 3'b100;
            TOK_01:  r = 3'b101;
            TOK_10:  r = 3'b110;
            TOK_11:  r = 3'b111;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Stage 1: input register and token detect on the raw input
    // ------------------------------------------------------------------
    logic [9:0] din_d, din_q;
    logic       tok_s1;

    // ------------------------------------------------------------------
    // Stage 2: decode
    // ------------------------------------------------------------------
    logic [2:0] tok_s2;
    logic [7:0] q_s2;
    logic [7:0] dec_s2;
    logic [7:0] dout_d, dout_q;
    logic       de_d, de_q;
    logic       c0_d, c0_q;
    logic       c1_d, c1_q;

    always_comb begin
        din_d  = bus.din;
        tok_s1 = (bus.din == TOK_00) || (bus.din == TOK_01) ||
                 (bus.din == TOK_10) || (bus.din == TOK_11);
    end

    always_comb begin
        tok_s2 = tok_lookup(din_q);
        // bit 9 flags that the encoder inverted the data bits
        q_s2   = din_q[9] ? ~din_q[7:0] : din_q[7:0];
        dec_s2 = 8'h00;
        dec_s2[0] = q_s2[0];
        // bit 8 selects XOR (1) or XNOR (0) transition coding
        for (int i = 1; i < 8; i++) begin
            dec_s2[i] = din_q[8] ? (q_s2[i] ^ q_s2[i-1]) : ~(q_s2[i] ^ q_s2[i-1]);
        end

        dout_d = dout_q;
        de_d   = de_q;
        c0_d   = c0_q;
        c1_d   = c1_q;
        if (tok_s2[2]) begin
            de_d   = 1'b0;
            dout_d = 8'h00;
            c1_d   = tok_s2[1];
            c0_d   = tok_s2[0];
        end else begin
            de_d   = 1'b1;
            dout_d = dec_s2;
        end
    end

    always_ff @(posedge clkin or posedge rstin) begin
        if (rstin) begin
            din_q  <= '0;
            dout_q <= '0;
            de_q   <= 1'b0;
            c0_q   <= 1'b0;
            c1_q   <= 1'b0;
        end else begin
            din_q  <= din_d;
            dout_q <= dout_d;
            de_q   <= de_d;
            c0_q   <= c0_d;
            c1_q   <= c1_d;
        end
    end

    assign bus.dout = dout_q;
    assign bus.de   = de_q;
    assign bus.c0   = c0_q;
    assign bus.c1   = c1_q;

`ifdef TMDS_ALIGN_EN
    // ------------------------------------------------------------------
    // Alignment FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SLIP   = 2'd1,
        ST_WAIT   = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    localparam logic [7:0]          LOCK_CNT_B  = 8'(LOCK_CNT);
    localparam logic [7:0]          SLIP_WAIT_B = 8'(SLIP_WAIT);
    localparam logic [SEARCH_W-1:0] TIMER_MAX   = '1;

    state_t              state_d, state_q;
    logic [SEARCH_W-1:0] timer_d, timer_q;
    logic [SEARCH_W-1:0] timer_inc;
    logic [7:0]          run_d, run_q;
    logic [7:0]          run_inc;
    logic [7:0]          wcnt_d, wcnt_q;
    logic                vld_d, vld_q;
    logic                bitslip_d, bitslip_q;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        run_d     = run_q;
        wcnt_d    = wcnt_q;
        timer_inc = timer_q + 1'b1;
        run_inc   = (run_q >= LOCK_CNT_B) ? LOCK_CNT_B : run_q + 8'd1;

        case (state_q)
            ST_SEARCH: begin
                timer_d = timer_inc;
                run_d   = tok_s1 ? run_inc : 8'd0;
                // lock wins over slip when both hit on the same cycle
                if (run_d == LOCK_CNT_B) begin
                    state_d = ST_LOCKED;
                    timer_d = '0;
                end else if (timer_inc == TIMER_MAX) begin
                    state_d = ST_SLIP;
                    timer_d = '0;
                    run_d   = 8'd0;
                end
            end
            ST_SLIP: begin
                state_d = ST_WAIT;
                wcnt_d  = 8'd0;
            end
            ST_WAIT: begin
                // deserializer is settling on the new boundary; tokens ignored
                wcnt_d = wcnt_q + 8'd1;
                if (wcnt_d == SLIP_WAIT_B) begin
                    state_d = ST_SEARCH;
                    timer_d = '0;
                    run_d   = 8'd0;
                    wcnt_d  = 8'd0;
                end
            end
            ST_LOCKED: begin
                timer_d = tok_s1 ? '0 : timer_inc;
                // loss of lock drops straight back to search, no slip
                if (!tok_s1 && (timer_inc == TIMER_MAX)) begin
                    state_d = ST_SEARCH;
                    timer_d = '0;
                    run_d   = 8'd0;
                    wcnt_d  = 8'd0;
                end
            end
            default: begin
                state_d = ST_SEARCH;
                timer_d = '0;
                run_d   = 8'd0;
                wcnt_d  = 8'd0;
            end
        endcase

        // vld follows the state one edge later; bitslip is high while in SLIP
        vld_d     = (state_q == ST_LOCKED);
        bitslip_d = (state_d == ST_SLIP);
    end

    always_ff @(posedge clkin or posedge rstin) begin
        if (rstin) begin
            state_q   <= ST_SEARCH;
            timer_q   <= '0;
            run_q     <= 8'd0;
            wcnt_q    <= 8'd0;
            vld_q     <= 1'b0;
            bitslip_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            run_q     <= run_d;
            wcnt_q    <= wcnt_d;
            vld_q     <= vld_d;
            bitslip_q <= bitslip_d;
        end
    end

    assign bus.vld     = vld_q;
    assign bus.bitslip = bitslip_q;
`else
    // Alignment removed: lane is assumed to be word-aligned externally.
    logic cfg_unused;
    assign cfg_unused  = ^{tok_s1, 8'(LOCK_CNT), 8'(SEARCH_W), 8'(SLIP_WAIT)};
    assign bus.vld     = 1'b1;
    assign bus.bitslip = 1'b0;
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
// tb/tb_tmds_decoder.sv - self-checking bench for tmds_decoder
module tb_tmds_decoder;

    logic clkin = 1'b0;
    logic rstin = 1'b1;

    tmds_decoder_if bus ();

    tmds_decoder #(
        .LOCK_CNT  (16),
        .SEARCH_W  (6),
        .SLIP_WAIT (8)
    ) dut (
        .clkin (clkin),
        .rstin (rstin),
        .bus   (bus)
    );

    always #5 clkin = ~clkin;

    int checks   = 0;
    int failures = 0;

    // scoreboard entry: {de, c1, c0, dout}
    logic [10:0] sb[$];
    logic [1:0]  model_c = 2'b00;

    localparam logic [9:0] T00  = 10'b1101010100;
    localparam logic [9:0] T01  = 10'b0010101011;
    localparam logic [9:0] T10  = 10'b0101010100;
    localparam logic [9:0] T11  = 10'b1010101011;
    localparam logic [9:0] D10  = 10'b0111110000;  // decodes to 0x10

    function automatic logic [10:0] obs();
        return {bus.de, bus.c1, bus.c0, bus.dout};
    endfunction

    // reference DVI encoder (transition-minimised stage, free choice of inversion)
    function automatic logic [9:0] encode(input logic [7:0] d, input logic inv);
        int n1;
        logic [8:0] qm;
        n1 = $countones(d);
        qm = '0;
        qm[0] = d[0];
        if (n1 > 4 || (n1 == 4 && d[0] == 1'b0)) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
            qm[8] = 1'b1;
        end
        return inv ? {1'b1, qm[8], ~qm[7:0]} : {1'b0, qm[8], qm[7:0]};
    endfunction

    function automatic logic [9:0] rotl(input logic [9:0] t, input int r);
        logic [19:0] w;
        w = {t, t} << r;
        return w[19:10];
    endfunction

    task automatic push_sym(input logic [9:0] sym, input logic [7:0] byte_exp);
        logic hit;
        logic [1:0] cb;
        hit = 1'b1;
        case (sym)
            T00: cb = 2'b00;
            T01: cb = 2'b01;
            T10: cb = 2'b10;
            T11: cb = 2'b11;
            default: begin hit = 1'b0; cb = 2'b00; end
        endcase
        if (hit) begin
            model_c = cb;
            sb.push_back({1'b0, cb, 8'h00});
        end else begin
            sb.push_back({1'b1, model_c, byte_exp});
        end
        bus.din = sym;
    endtask

    task automatic test_reset();
        logic exp_vld;
`ifdef TMDS_ALIGN_EN
        exp_vld = 1'b0;
`else
        exp_vld = 1'b1;
`endif
        checks++;
        if (obs() !== 11'h000) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=%h", obs(), 11'h000);
        end
        checks++;
        if (bus.vld !== exp_vld || bus.bitslip !== 1'b0) begin
            failures++;
            $display("FAIL reset_vld_bitslip got=%b%b exp=%b0", bus.vld, bus.bitslip, exp_vld);
        end
    endtask

    task automatic test_basic();
        logic [10:0] e;
        for (int i = 0; i < 24; i++) begin
            @(negedge clkin);
            if (sb.size() >= 2) begin
                e = sb.pop_front();
                checks++;
                if (obs() !== e) begin
                    failures++;
                    $display("FAIL basic step=%0d got=%h exp=%h", i, obs(), e);
                end
            end
            push_sym((i == 20) ? D10 : T00, 8'h10);
        end
    endtask

    task automatic test_tokens();
        logic [10:0] e;
        logic [9:0] seq [8];
        seq = '{T00, T01, T10, T11, D10, D10, T01, D10};
        for (int i = 0; i < 8; i++) begin
            @(negedge clkin);
            if (sb.size() >= 2) begin
                e = sb.pop_front();
                checks++;
                if (obs() !== e) begin
                    failures++;
                    $display("FAIL tokens step=%0d got=%h exp=%h", i, obs(), e);
                end
            end
            push_sym(seq[i], 8'h10);
        end
    endtask

    task automatic test_encoder();
        logic [10:0] e;
        for (int b = 0; b < 256; b++) begin
            @(negedge clkin);
            if (sb.size() >= 2) begin
                e = sb.pop_front();
                checks++;
                if (obs() !== e) begin
                    failures++;
                    $display("FAIL encoder byte=%0d got=%h exp=%h", b, obs(), e);
                end
            end
            push_sym(encode(8'(b), 1'($urandom_range(0, 1))), 8'(b));
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] e;
        logic [7:0]  b;
        logic [9:0]  toks [4];
        toks = '{T00, T01, T10, T11};
        for (int i = 0; i < 202; i++) begin
            @(negedge clkin);
            if (sb.size() >= 2) begin
                e = sb.pop_front();
                checks++;
                if (obs() !== e) begin
                    failures++;
                    $display("FAIL back_to_back step=%0d got=%h exp=%h", i, obs(), e);
                end
            end
            b = 8'($urandom_range(0, 255));
            if (i >= 200 || $urandom_range(0, 3) == 0)
                push_sym(toks[$urandom_range(0, 3)], 8'h00);
            else
                push_sym(encode(b, 1'($urandom_range(0, 1))), b);
        end
        sb.delete();
    endtask

`ifdef TMDS_ALIGN_EN
    task automatic test_align();
        int cyc, rot, nslip, rise_t, fall_m;
        int slip_t [4];
        logic drop, bs;
        // lane shifted by 3 bits: the token stream arrives rotated
        @(negedge clkin);
        rstin = 1'b1;
        rot = 3;
        bus.din = rotl(T00, rot);
        @(negedge clkin);
        rstin = 1'b0;
        cyc = 0; nslip = 0; rise_t = 0;
        slip_t = '{0, 0, 0, 0};
        while (cyc < 400 && !(rise_t != 0 && cyc >= rise_t + 5)) begin
            @(negedge clkin);
            cyc++;
            if (bus.bitslip === 1'b1) begin
                if (nslip < 4) slip_t[nslip] = cyc;
                nslip++;
                rot = (rot + 9) % 10;
            end
            if (bus.vld === 1'b1 && rise_t == 0) rise_t = cyc;
            bus.din = rotl(T00, rot);
        end
        checks++;
        if (nslip != 3) begin
            failures++;
            $display("FAIL slip_count got=%0d exp=3", nslip);
        end
        checks++;
        if (slip_t[0] != 63 || slip_t[1] != 135 || slip_t[2] != 207) begin
            failures++;
            $display("FAIL slip_times got=%0d,%0d,%0d exp=63,135,207", slip_t[0], slip_t[1], slip_t[2]);
        end
        checks++;
        if (rise_t != 233) begin
            failures++;
            $display("FAIL vld_rise got=%0d exp=233", rise_t);
        end

        // keep-alive: one token every 62 cycles holds lock
        drop = 1'b0; bs = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clkin);
            if (bus.vld !== 1'b1) drop = 1'b1;
            if (bus.bitslip !== 1'b0) bs = 1'b1;
            bus.din = (k % 62 == 0) ? T00 : D10;
        end
        checks++;
        if (drop || bs) begin
            failures++;
            $display("FAIL keep_alive got=drop%b slip%b exp=drop0 slip0", drop, bs);
        end

        // loss of lock: a last token, then 63 cycles of data
        @(negedge clkin);
        bus.din = T00;
        fall_m = 0; bs = 1'b0;
        for (int m = 1; m <= 100 && fall_m == 0; m++) begin
            @(negedge clkin);
            if (bus.bitslip !== 1'b0) bs = 1'b1;
            if (bus.vld !== 1'b1) fall_m = m;
            bus.din = D10;
        end
        checks++;
        if (fall_m != 65 || bs) begin
            failures++;
            $display("FAIL loss_of_lock got=fall%0d slip%b exp=fall65 slip0", fall_m, bs);
        end
    endtask

    task automatic test_reset_in_wait();
        int s, first;
        s = 0;
        for (int i = 0; i < 200 && s == 0; i++) begin
            @(negedge clkin);
            if (bus.bitslip === 1'b1) s = i + 1;
            bus.din = D10;
        end
        checks++;
        if (s == 0) begin
            failures++;
            $display("FAIL wait_slip_seen got=none exp=pulse");
        end
        repeat (3) @(negedge clkin);
        #2 rstin = 1'b1;
        #1;
        checks++;
        if ({obs(), bus.vld, bus.bitslip} !== 13'h0) begin
            failures++;
            $display("FAIL reset_in_wait got=%h exp=0", {obs(), bus.vld, bus.bitslip});
        end
        @(negedge clkin);
        rstin = 1'b0;
        first = 0;
        for (int c = 1; c <= 150 && first == 0; c++) begin
            @(negedge clkin);
            if (bus.bitslip === 1'b1) first = c;
        end
        checks++;
        if (first != 63) begin
            failures++;
            $display("FAIL first_slip_after_reset got=%0d exp=63", first);
        end
    endtask
`else
    task automatic test_align();
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clkin);
            if (bus.vld !== 1'b1 || bus.bitslip !== 1'b0) bad = 1'b1;
            bus.din = rotl(T00, 3);
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL align_disabled got=vld%b slip%b exp=vld1 slip0", bus.vld, bus.bitslip);
        end
    endtask

    task automatic test_reset_in_wait();
    endtask
`endif

    initial begin
        bus.din = 10'h000;
        rstin   = 1'b1;
        repeat (3) @(negedge clkin);
        test_reset();
        rstin = 1'b0;
        test_basic();
        test_tokens();
        test_encoder();
        test_back_to_back();
        test_align();
        test_reset_in_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
